banked_sram_buffer: RTL and testbench

Parametrised multi-bank scratchpad buffer for the systolic array datapath. It holds NUM_BANKS independent banks, each one DATA_WIDTH wide and 2**ADDR_WIDTH deep. Each bank services one fixed-latency read or write at a time and reports completion explicitly through per-bank ready, read-valid and write-done handshakes. It sits between the load/store controller and the array's input, weight and output feeders, and replaces the fixed 4x64-bit buffer.

---
 rtl/banked_sram_buffer.sv | 121 ++++++++++++
 tb/tb_banked_sram_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_sram_buffer.sv
// Multi-bank scratchpad buffer for the systolic array datapath.
// Holds NUM_BANKS independent banks, each DATA_WIDTH wide and 2**ADDR_WIDTH deep. Each bank runs
// one fixed-latency read or write at a time and signals completion with one-cycle pulses.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   chip_select  per-bank request strobe
//   ren / wen    shared read / write request
//   addr         shared word address
//   write_data   per-bank write words, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-bank idle flag
//   read_data    last completed read word per bank, same slicing as write_data
//   read_valid   per-bank pulse, read_data slice updated
//   write_done   per-bank pulse, write committed
//   op_error     per-bank pulse, request with both ren and wen rejected
module banked_sram_buffer #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_BANKS-1:0]            chip_select,
  input  logic                            ren,
  input  logic                            wen,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] write_data,
  output logic [NUM_BANKS-1:0]            req_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] read_data,
  output logic [NUM_BANKS-1:0]            read_valid,
  output logic [NUM_BANKS-1:0]            write_done,
  output logic [NUM_BANKS-1:0]            op_error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(LATENCY + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  logic op_legal;
  logic op_both;

  assign op_legal = ren ^ wen;
  assign op_both  = ren & wen;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic                    is_write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic                    wdone_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [Depth];
    logic                    sel_idle;
    logic                    commit;

    assign sel_idle = chip_select[b] && (state_q == StIdle);
    assign commit   = (state_q == StBusy) && (cnt_q == CntW'(1));

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        is_write_q <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        rdata_q    <= '0;
        rvalid_q   <= 1'b0;
        wdone_q    <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        rvalid_q <= 1'b0;
        wdone_q  <= 1'b0;
        err_q    <= sel_idle && op_both;
        unique case (state_q)
          StIdle: begin
            if (sel_idle && op_legal) begin
              is_write_q <= wen;
              addr_q     <= addr;
              wdata_q    <= write_data[b*DATA_WIDTH +: DATA_WIDTH];
              cnt_q      <= CntW'(LATENCY);
              state_q    <= StBusy;
            end
          end
          StBusy: begin
            cnt_q <= cnt_q - CntW'(1);
            if (commit) begin
              state_q <= StIdle;
              if (is_write_q) begin
                wdone_q <= 1'b1;
              end else begin
                rdata_q  <= mem[addr_q];
                rvalid_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    // Storage is deliberately not reset; commit is already low while n_rst holds state idle.
    always_ff @(posedge clk) begin
      if (commit && is_write_q) begin
        mem[addr_q] <= wdata_q;
      end
    end

    assign req_ready[b]                           = (state_q == StIdle);
    assign read_data[b*DATA_WIDTH +: DATA_WIDTH]  = rdata_q;
    assign read_valid[b]                          = rvalid_q;
    assign write_done[b]                          = wdone_q;
    assign op_error[b]                            = err_q;
  end

endmodule

// File: tb/tb_banked_sram_buffer.sv
// Scoreboard bench for banked_sram_buffer: the driver pushes expected completions per bank, a
// negedge monitor pops them when due and compares pulses, ready flags and read data.
module tb_banked_sram_buffer;

  localparam int NB    = 4;
  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int LAT   = 4;
  localparam int Depth = 1 << AW;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NB-1:0]     chip_select = '0;
  logic              ren = 1'b0;
  logic              wen = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [NB*DW-1:0]  write_data = '0;
  logic [NB-1:0]     req_ready;
  logic [NB*DW-1:0]  read_data;
  logic [NB-1:0]     read_valid;
  logic [NB-1:0]     write_done;
  logic [NB-1:0]     op_error;

  banked_sram_buffer #(
    .NUM_BANKS (NB),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .chip_select(chip_select),
    .ren        (ren),
    .wen        (wen),
    .addr       (addr),
    .write_data (write_data),
    .req_ready  (req_ready),
    .read_data  (read_data),
    .read_valid (read_valid),
    .write_done (write_done),
    .op_error   (op_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // kind: 0 read, 1 write, 2 rejected request
  typedef struct {
    int            kind;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            due;
  } ev_t;

  ev_t           q [NB][$];
  int            busy_until [NB];
  logic [DW-1:0] mdl_mem [NB][Depth];
  bit            known [NB][Depth];
  logic [DW-1:0] last_rd [NB];
  bit            last_known [NB];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input int b, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s bank %0d cycle %0d: got %h expected %h", name, b, cyc, act, exp);
    end
  endtask

  // Monitor: completions scheduled for this cycle must show up as pulses, nothing else may.
  initial begin
    ev_t e;
    bit  er, ew, ee;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int b = 0; b < NB; b++) begin
          er = 1'b0;
          ew = 1'b0;
          ee = 1'b0;
          if (q[b].size() > 0 && q[b][0].due == cyc) begin
            e = q[b].pop_front();
            if (e.kind == 0) begin
              er            = 1'b1;
              last_rd[b]    = mdl_mem[b][e.a];
              last_known[b] = known[b][e.a];
            end else if (e.kind == 1) begin
              ew              = 1'b1;
              mdl_mem[b][e.a] = e.d;
              known[b][e.a]   = 1'b1;
            end else begin
              ee = 1'b1;
            end
          end
          chk("req_ready", b, DW'(req_ready[b]), DW'(cyc >= busy_until[b]));
          chk("read_valid", b, DW'(read_valid[b]), DW'(er));
          chk("write_done", b, DW'(write_done[b]), DW'(ew));
          chk("op_error", b, DW'(op_error[b]), DW'(ee));
          if (last_known[b]) chk("read_data", b, read_data[b*DW +: DW], last_rd[b]);
        end
      end
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    #1;
  endtask

  // Drive one cycle of request; the model decides which banks take it at the coming edge.
  task automatic issue(input logic [NB-1:0] cs, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [NB*DW-1:0] wd);
    ev_t e;
    int  edge_n;
    chip_select = cs;
    ren         = r;
    wen         = w;
    addr        = a;
    write_data  = wd;
    edge_n      = cyc + 1;
    for (int b = 0; b < NB; b++) begin
      if (cs[b] && edge_n > busy_until[b]) begin
        e.a = a;
        e.d = wd[b*DW +: DW];
        if (r != w) begin
          e.kind        = w ? 1 : 0;
          e.due         = edge_n + LAT;
          busy_until[b] = e.due;
          q[b].push_back(e);
        end else if (r && w) begin
          e.kind = 2;
          e.due  = edge_n;
          q[b].push_back(e);
        end
      end
    end
    idle_cycle();
    chip_select = '0;
    ren         = 1'b0;
    wen         = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 40) begin
      idle_cycle();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_idle: got %0d pending after %0d cycles, expected 0", q[0].size(), n);
    end
    idle_cycle();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    for (int b = 0; b < NB; b++) begin
      q[b].delete();
      busy_until[b] = cyc;
      last_rd[b]    = '0;
      last_known[b] = 1'b1;
    end
    idle_cycle();
    idle_cycle();
    n_rst = 1'b1;
  endtask

  function automatic logic [NB*DW-1:0] rand_wd();
    logic [NB*DW-1:0] v;
    for (int i = 0; i < NB * DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [NB*DW-1:0] wd;
    logic [NB-1:0]    cs;
    int               op;
    for (int b = 0; b < NB; b++) begin
      busy_until[b] = 0;
      last_rd[b]    = '0;
      last_known[b] = 1'b1;
      for (int a = 0; a < Depth; a++) known[b][a] = 1'b0;
    end
    do_reset();
    mon_en = 1'b1;
    idle_cycle();

    // Single read from reset-idle bank 0
    issue(4'b0001, 1'b1, 1'b0, 10'h005, '0);
    wait_idle();

    // Write then read back bank 2 at the top address
    wd = '0;
    wd[2*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
    issue(4'b0100, 1'b0, 1'b1, 10'h3FF, wd);
    wait_idle();
    issue(4'b0100, 1'b1, 1'b0, 10'h3FF, '0);
    wait_idle();

    // Broadcast write of distinct words, then broadcast read
    wd = rand_wd();
    issue(4'b1111, 1'b0, 1'b1, 10'h010, wd);
    wait_idle();
    issue(4'b1111, 1'b1, 1'b0, 10'h010, '0);
    wait_idle();

    // Chip select held on busy bank 1: model accepts once per LAT+1 cycles
    for (int i = 0; i < 16; i++) issue(4'b0010, 1'b1, 1'b0, 10'h010, '0);
    wait_idle();

    // Illegal request on bank 0
    issue(4'b0001, 1'b1, 1'b1, 10'h020, rand_wd());
    wait_idle();

    // Reset two cycles into a read on bank 3; earlier write must survive
    issue(4'b1000, 1'b0, 1'b1, 10'h020, rand_wd());
    wait_idle();
    issue(4'b1000, 1'b1, 1'b0, 10'h020, '0);
    idle_cycle();
    do_reset();
    idle_cycle();
    issue(4'b1000, 1'b1, 1'b0, 10'h020, '0);
    wait_idle();

    // Random traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      cs = NB'($urandom);
      op = $urandom_range(0, 9);
      if (op == 0) issue(cs, 1'b1, 1'b1, AW'(10'h100 + $urandom_range(0, 7)), rand_wd());
      else if (op == 1) issue(cs, 1'b0, 1'b0, AW'(10'h100 + $urandom_range(0, 7)), rand_wd());
      else if (op < 6) issue(cs, 1'b1, 1'b0, AW'(10'h100 + $urandom_range(0, 7)), rand_wd());
      else issue(cs, 1'b0, 1'b1, AW'(10'h100 + $urandom_range(0, 7)), rand_wd());
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    wait_idle();
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
